// File: rtl/sm_input_filter_if.sv
// Pin-side bus for sm_input_filter: raw inputs, threshold, filtered level and edge strobes.
// Irq signals exist only when SM_INPUT_FILTER_IRQ_EN is defined.
interface sm_input_filter_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     d;
    logic [CNT_WIDTH-1:0] holdTime;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     fall;
`ifdef SM_INPUT_FILTER_IRQ_EN
    logic [WIDTH-1:0]     irqMask;
    logic [WIDTH-1:0]     irqClear;
    logic [WIDTH-1:0]     evtPending;
    logic                 irq;
`endif

    modport master (
        output d, holdTime,
`ifdef SM_INPUT_FILTER_IRQ_EN
        output irqMask, irqClear,
        input  evtPending, irq,
`endif
        input  q, rise, fall
    );

    modport slave (
        input  d, holdTime,
`ifdef SM_INPUT_FILTER_IRQ_EN
        input  irqMask, irqClear,
        output evtPending, irq,
`endif
        output q, rise, fall
    );
endinterface

// File: rtl/sm_input_filter.sv
// Multi-channel input conditioner: synchroniser, programmable stability filter, rise/fall strobes.
// Define SM_INPUT_FILTER_IRQ_EN to add sticky per-channel event flags and an irq output.
module sm_input_filter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic            clk,
    input logic            rst,
    sm_input_filter_if.slave bus
);
    logic [WIDTH-1:0]     syncChain [SYNC_STAGES];
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     qReg;
    logic [WIDTH-1:0]     riseReg;
    logic [WIDTH-1:0]     fallReg;
    logic [CNT_WIDTH-1:0] cnt [WIDTH];

    assign s = syncChain[SYNC_STAGES-1];

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                syncChain[k] <= '0;
            end
        end else begin
            syncChain[0] <= bus.d;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                syncChain[k] <= syncChain[k-1];
            end
        end
    end

    // >= lets a lowered holdTime release an in-progress count on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            qReg    <= '0;
            riseReg <= '0;
            fallReg <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                riseReg[i] <= 1'b0;
                fallReg[i] <= 1'b0;
                if (s[i] == qReg[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= bus.holdTime) begin
                    qReg[i]    <= s[i];
                    cnt[i]     <= '0;
                    riseReg[i] <= s[i];
                    fallReg[i] <= ~s[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.q    = qReg;
    assign bus.rise = riseReg;
    assign bus.fall = fallReg;

`ifdef SM_INPUT_FILTER_IRQ_EN
    logic [WIDTH-1:0] evtPendingReg;

    // A new strobe overrides a same-cycle clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            evtPendingReg <= '0;
        end else begin
            evtPendingReg <= (evtPendingReg & ~bus.irqClear) |
                             ((riseReg | fallReg) & bus.irqMask);
        end
    end

    assign bus.evtPending = evtPendingReg;
    assign bus.irq        = |evtPendingReg;
`endif
endmodule
